// File: rtl/ps2_pkg.sv
// Purpose : shared constants, FSM encoding and helpers for the PS/2 set-2 scan decoder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: prefix bytes (E0/F0/E1/AA), modifier and caps key codes, prefix FSM states,
//           key identity struct and modifier classification helper.
package ps2_pkg;

  // Set-2 prefix and status bytes
  localparam logic [7:0] PS2_E0  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_F0  = 8'hF0;  // break prefix
  localparam logic [7:0] PS2_E1  = 8'hE1;  // pause sequence lead byte
  localparam logic [7:0] PS2_BAT = 8'hAA;  // self-test passed, not a key

  // Key codes that drive decoder-side state
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Bytes still to swallow after the E1 that opens the 8-byte pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_id_t;

  // Modifier keys are tracked as state and never counted as presses
  function automatic logic is_modifier(input logic [7:0] code);
    return (code == KEY_LSHIFT) || (code == KEY_RSHIFT) ||
           (code == KEY_CTRL)   || (code == KEY_ALT);
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Purpose : abort timer for a partially received prefix sequence.
// Latency : o_expire is combinational, true on the TIMEOUT_CYC-th consecutive running cycle without a clear.
// Backpressure: none; counts every cycle i_run is high.
// Ports   : i_clk, i_clrn (async active-low reset), i_clr (restart count), i_run (count enable),
//           o_expire (limit reached this cycle; counter self-clears).
module ps2_prefix_timer #(
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter int unsigned TW          = 23
) (
  input  logic i_clk,
  input  logic i_clrn,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_cnt;

  // A clear in the same cycle wins: a byte arriving right at the limit still completes the sequence
  assign o_expire = i_run && !i_clr && (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_cnt <= '0;
    end else if (i_clr || !i_run || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Purpose : pops set-2 scan bytes from the PS/2 receiver FIFO and resolves E0/F0/E1 prefixes into key events,
//           tracking shift/ctrl/alt, caps-lock toggle and a count of new key presses.
// Latency : byte captured in cycle T; pop strobe and the resulting event/err are registered and visible in T+1.
// Backpressure: captures only when i_rx_ready and not in the post-pop gap (max 1 byte / 2 cycles); no capture or
//           pop while i_rx_overflow is high.
// Ports   : i_clk, i_clrn (async active-low reset), i_rx_data/i_rx_ready/i_rx_overflow from the FIFO,
//           o_rx_nextdata_n (active-low pop), o_evt_valid/o_evt_code/o_evt_ext/o_evt_make (event, fields held),
//           o_shift/o_ctrl/o_alt/o_caps (key state), o_press_cnt (wrapping make count), o_err (error pulse).
// Option  : define PS2DEC_REPEAT_FILTER_EN to suppress typematic repeats of the last held make.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter int unsigned TW          = 23
) (
  input  logic       i_clk,
  input  logic       i_clrn,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  input  logic       i_rx_overflow,
  output logic       o_rx_nextdata_n,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_make,
  output logic       o_shift,
  output logic       o_ctrl,
  output logic       o_alt,
  output logic       o_caps,
  output logic [7:0] o_press_cnt,
  output logic       o_err
);

  ps2_state_e r_state, w_state_nxt;
  logic [2:0] r_skip, w_skip_nxt;

  logic       r_gap;          // high in the cycle after a capture: pop strobe and no capture
  logic       r_evt_vld;
  logic [7:0] r_evt_code;
  logic       r_evt_ext;
  logic       r_evt_make;
  logic       r_lshift, r_rshift, r_ctrl, r_alt;
  logic       r_caps, r_caps_held;
  logic [7:0] r_press_cnt;
  logic       r_err;

  logic       w_cap;
  logic       w_expire;
  logic       w_dec_vld;
  logic [7:0] w_dec_code;
  logic       w_dec_ext;
  logic       w_dec_make;
  logic       w_bad_byte;
  logic       w_tmo;
  logic       w_repeat;
  logic       w_evt;

  assign w_cap = i_rx_ready && !r_gap && !i_rx_overflow;

  ps2_prefix_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TW          (TW)
  ) u_timer (
    .i_clk    (i_clk),
    .i_clrn   (i_clrn),
    .i_clr    (w_cap || i_rx_overflow),
    .i_run    (r_state != ST_IDLE),
    .o_expire (w_expire)
  );

  // ---------------------------------------------------------------- prefix FSM
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_dec_vld   = 1'b0;
    w_dec_code  = i_rx_data;
    w_dec_ext   = 1'b0;
    w_dec_make  = 1'b0;
    w_bad_byte  = 1'b0;
    w_tmo       = 1'b0;

    if (i_rx_overflow) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cap) begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_rx_data == PS2_E0) begin
            w_state_nxt = ST_EXT;
          end else if (i_rx_data == PS2_F0) begin
            w_state_nxt = ST_BRK;
          end else if (i_rx_data == PS2_E1) begin
            w_state_nxt = ST_PAUSE;
            w_skip_nxt  = PAUSE_SKIP;
          end else if (i_rx_data == 8'h00 || i_rx_data == 8'hFF) begin
            // keyboard error / buffer overrun codes
            w_bad_byte = 1'b1;
          end else if (i_rx_data != PS2_BAT) begin
            w_dec_vld  = 1'b1;
            w_dec_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (i_rx_data == PS2_F0) begin
            w_state_nxt = ST_EXTBRK;
          end else begin
            w_state_nxt = ST_IDLE;
            // E0 12 / E0 59 are fake shifts wrapped around nav keys; drop them
            if (i_rx_data != KEY_LSHIFT && i_rx_data != KEY_RSHIFT) begin
              w_dec_vld  = 1'b1;
              w_dec_ext  = 1'b1;
              w_dec_make = 1'b1;
            end
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          w_dec_vld   = 1'b1;
        end
        ST_EXTBRK: begin
          w_state_nxt = ST_IDLE;
          w_dec_vld   = 1'b1;
          w_dec_ext   = 1'b1;
        end
        ST_PAUSE: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            // pause has no break; report the whole sequence as one make of E1
            w_state_nxt = ST_IDLE;
            w_dec_vld   = 1'b1;
            w_dec_code  = PS2_E1;
            w_dec_make  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_state_nxt = ST_IDLE;
      w_tmo       = 1'b1;
    end
  end

  // ---------------------------------------------------------------- repeat filter
`ifdef PS2DEC_REPEAT_FILTER_EN
  key_id_t w_key;
  key_id_t r_last_key;
  logic    r_last_vld;

  assign w_key    = '{ext: w_dec_ext, code: w_dec_code};
  assign w_repeat = w_dec_vld && w_dec_make && r_last_vld && (r_last_key == w_key);

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_last_vld <= 1'b0;
      r_last_key <= '0;
    end else if (i_rx_overflow) begin
      // held-key knowledge is lost with the dropped bytes, same as the modifiers
      r_last_vld <= 1'b0;
    end else if (w_dec_vld) begin
      if (w_dec_make) begin
        r_last_vld <= 1'b1;
        r_last_key <= w_key;
      end else if (r_last_vld && r_last_key == w_key) begin
        r_last_vld <= 1'b0;
      end
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign w_evt = w_dec_vld && !w_repeat;

  // ---------------------------------------------------------------- outputs and key state
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_gap       <= 1'b0;
      r_evt_vld   <= 1'b0;
      r_evt_code  <= '0;
      r_evt_ext   <= 1'b0;
      r_evt_make  <= 1'b0;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_ctrl      <= 1'b0;
      r_alt       <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_press_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_gap     <= w_cap;
      r_evt_vld <= w_evt;
      r_err     <= i_rx_overflow || w_bad_byte || w_tmo;

      if (w_evt) begin
        r_evt_code <= w_dec_code;
        r_evt_ext  <= w_dec_ext;
        r_evt_make <= w_dec_make;

        if (w_dec_code == KEY_LSHIFT && !w_dec_ext) r_lshift <= w_dec_make;
        if (w_dec_code == KEY_RSHIFT && !w_dec_ext) r_rshift <= w_dec_make;
        if (w_dec_code == KEY_CTRL) r_ctrl <= w_dec_make;
        if (w_dec_code == KEY_ALT)  r_alt  <= w_dec_make;

        // caps toggles once per physical press; typematic makes are ignored until release
        if (w_dec_code == KEY_CAPS && !w_dec_ext) begin
          if (w_dec_make) begin
            if (!r_caps_held) begin
              r_caps      <= ~r_caps;
              r_caps_held <= 1'b1;
            end
          end else begin
            r_caps_held <= 1'b0;
          end
        end

        if (w_dec_make && !is_modifier(w_dec_code)) begin
          r_press_cnt <= r_press_cnt + 8'd1;
        end
      end

      if (i_rx_overflow) begin
        r_lshift <= 1'b0;
        r_rshift <= 1'b0;
        r_ctrl   <= 1'b0;
        r_alt    <= 1'b0;
      end
    end
  end

  assign o_rx_nextdata_n = ~r_gap;
  assign o_evt_valid     = r_evt_vld;
  assign o_evt_code      = r_evt_code;
  assign o_evt_ext       = r_evt_ext;
  assign o_evt_make      = r_evt_make;
  assign o_shift         = r_lshift | r_rshift;
  assign o_ctrl          = r_ctrl;
  assign o_alt           = r_alt;
  assign o_caps          = r_caps;
  assign o_press_cnt     = r_press_cnt;
  assign o_err           = r_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Purpose : directed + random bench for ps2_scan_decoder against a byte-list reference model.
// Latency : expects each event/err in the cycle the pop strobe is low.
// Backpressure: feeds one byte at a time, holding i_rx_ready until the pop strobe appears.
module tb_ps2_scan_decoder;

  localparam int TMO = 40;

`ifdef PS2DEC_REPEAT_FILTER_EN
  localparam logic [7:0] REP_CNT = 8'd1;
`else
  localparam logic [7:0] REP_CNT = 8'd3;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_overflow = 1'b0;
  logic       rx_nextdata_n;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_make;
  logic       shift, ctrl, alt, caps, err;
  logic [7:0] press_cnt;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.TIMEOUT_CYC(TMO), .TW(8)) dut (
    .i_clk           (clk),
    .i_clrn          (clrn),
    .i_rx_data       (rx_data),
    .i_rx_ready      (rx_ready),
    .i_rx_overflow   (rx_overflow),
    .o_rx_nextdata_n (rx_nextdata_n),
    .o_evt_valid     (evt_valid),
    .o_evt_code      (evt_code),
    .o_evt_ext       (evt_ext),
    .o_evt_make      (evt_make),
    .o_shift         (shift),
    .o_ctrl          (ctrl),
    .o_alt           (alt),
    .o_caps          (caps),
    .o_press_cnt     (press_cnt),
    .o_err           (err)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- reference model
  // Bytes of an unfinished sequence are kept as a list; a sequence is resolved by pattern.
  logic [7:0] pend[$];
  logic       m_lsh, m_rsh, m_ctrl, m_alt, m_caps, m_caps_held;
  logic [7:0] m_code, m_cnt;
  logic       m_ext, m_make;
  logic       m_last_vld;
  logic [8:0] m_last;
  logic       e_vld, e_err;

  task automatic model_reset();
    pend.delete();
    m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_caps_held = 0;
    m_code = 8'h00; m_cnt = 8'h00; m_ext = 0; m_make = 0;
    m_last_vld = 0; m_last = '0; e_vld = 0; e_err = 0;
  endtask

  task automatic model_emit(input logic [7:0] code, input logic ext, input logic make);
`ifdef PS2DEC_REPEAT_FILTER_EN
    if (make && m_last_vld && m_last == {ext, code}) return;
    if (make) begin
      m_last_vld = 1; m_last = {ext, code};
    end else if (m_last_vld && m_last == {ext, code}) begin
      m_last_vld = 0;
    end
`endif
    e_vld = 1; m_code = code; m_ext = ext; m_make = make;
    if (code == 8'h12 && !ext) m_lsh = make;
    if (code == 8'h59 && !ext) m_rsh = make;
    if (code == 8'h14) m_ctrl = make;
    if (code == 8'h11) m_alt = make;
    if (code == 8'h58 && !ext) begin
      if (!make) m_caps_held = 0;
      else if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
    end
    if (make && !(code inside {8'h12, 8'h59, 8'h14, 8'h11})) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int  n;
    logic ext, brk;
    e_vld = 0; e_err = 0;
    pend.push_back(b);
    n = pend.size();
    if (pend[0] == 8'hE1) begin
      if (n == 8) begin pend.delete(); model_emit(8'hE1, 1'b0, 1'b1); end
      return;
    end
    if (n == 1 && (b == 8'hE0 || b == 8'hF0)) return;
    if (n == 2 && pend[0] == 8'hE0 && b == 8'hF0) return;
    ext = (pend[0] == 8'hE0);
    brk = (n >= 2) && (pend[n-2] == 8'hF0);
    pend.delete();
    if (n == 1 && (b == 8'h00 || b == 8'hFF)) begin e_err = 1; return; end
    if (n == 1 && b == 8'hAA) return;
    if (ext && !brk && (b == 8'h12 || b == 8'h59)) return;
    model_emit(b, ext, !brk);
  endtask

  task automatic model_ovf();
    pend.delete();
    m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_last_vld = 0;
    e_vld = 0; e_err = 1;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vld"},   evt_valid, e_vld);
    chk({tag, ".code"},  evt_code,  m_code);
    chk({tag, ".ext"},   evt_ext,   m_ext);
    chk({tag, ".make"},  evt_make,  m_make);
    chk({tag, ".shift"}, shift,     m_lsh | m_rsh);
    chk({tag, ".ctrl"},  ctrl,      m_ctrl);
    chk({tag, ".alt"},   alt,       m_alt);
    chk({tag, ".caps"},  caps,      m_caps);
    chk({tag, ".cnt"},   press_cnt, m_cnt);
    chk({tag, ".err"},   err,       e_err);
  endtask

  // Present one byte (called at a negedge); returns at the negedge where the pop strobe is low.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_ready = 1'b1;
    rx_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (rx_nextdata_n && n < 8);
    chk("pop", rx_nextdata_n, 1'b0);
    rx_ready = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] b, input string tag);
    model_byte(b);
    send_byte(b);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0; rx_ready = 1'b0; rx_overflow = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst.nextdata_n", rx_nextdata_n, 1'b1);
    check_all("rst");
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic ovf_pulse(input string tag);
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;
    model_ovf();
    check_all(tag);
  endtask

  logic [7:0] rb;
  int         first_err, err_cycles, evt_cycles, sel;

  initial begin
    model_reset();
    do_reset();

    // make / break of a plain key, single-cycle pop and event pulse
    send_chk(8'h1C, "t1.make");
    chk("t1.make_code", evt_code, 8'h1C);
    @(negedge clk);
    chk("t1.pop_once", rx_nextdata_n, 1'b1);
    chk("t1.vld_pulse", evt_valid, 1'b0);
    chk("t1.code_hold", evt_code, 8'h1C);
    e_vld = 0;
    send_chk(8'hF0, "t1.f0");
    send_chk(8'h1C, "t1.brk");
    chk("t1.brk_make", evt_make, 1'b0);
    chk("t1.cnt1", press_cnt, 8'h01);

    // extended make / break, fake shift
    send_chk(8'hE0, "t2.e0");
    send_chk(8'h75, "t2.make");
    chk("t2.ext_make", {evt_valid, evt_ext, evt_make}, 3'b111);
    send_chk(8'hE0, "t2.e0b");
    send_chk(8'hF0, "t2.f0");
    send_chk(8'h75, "t2.brk");
    chk("t2.ext_brk", {evt_valid, evt_ext, evt_make}, 3'b110);
    send_chk(8'hE0, "t2.e0c");
    send_chk(8'h12, "t2.fake");
    chk("t2.fake_none", evt_valid, 1'b0);

    // shift held across another key
    do_reset();
    send_chk(8'h12, "t3.sh");
    send_chk(8'h1C, "t3.key");
    chk("t3.shift_on", shift, 1'b1);
    send_chk(8'hF0, "t3.f0");
    send_chk(8'h12, "t3.shrel");
    chk("t3.shift_off", shift, 1'b0);
    chk("t3.cnt", press_cnt, 8'h01);

    // caps toggle with hold
    do_reset();
    send_chk(8'h58, "t4.c1"); chk("t4.caps1", caps, 1'b1);
    send_chk(8'hF0, "t4.f0");
    send_chk(8'h58, "t4.rel"); chk("t4.caps2", caps, 1'b1);
    send_chk(8'h58, "t4.c2"); chk("t4.caps3", caps, 1'b0);
    send_chk(8'h58, "t4.c3"); chk("t4.caps4", caps, 1'b0);

    // asynchronous reset in the middle of a prefix
    send_chk(8'h12, "t5.sh");
    send_chk(8'hE0, "t5.e0");
    clrn = 1'b0;
    #1;
    model_reset();
    check_all("t5.arst");
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    send_chk(8'h75, "t5.after");
    chk("t5.plain", evt_ext, 1'b0);

    // typematic repeats
    do_reset();
    send_chk(8'h1C, "t6.r1");
    send_chk(8'h1C, "t6.r2");
    send_chk(8'h1C, "t6.r3");
    send_chk(8'hF0, "t6.f0");
    send_chk(8'h1C, "t6.rel");
    chk("t6.cnt", press_cnt, REP_CNT);

    // prefix timeout: err on the TMO-th stalled cycle after the F0 pop cycle
    do_reset();
    send_chk(8'hF0, "t7.f0");
    first_err = -1; err_cycles = 0; evt_cycles = 0;
    for (int k = 1; k <= TMO + 3; k++) begin
      @(negedge clk);
      if (err) begin
        err_cycles++;
        if (first_err < 0) first_err = k;
      end
      if (evt_valid) evt_cycles++;
    end
    chk("t7.tmo_cycle", first_err, TMO);
    chk("t7.err_pulses", err_cycles, 1);
    chk("t7.no_evt", evt_cycles, 0);
    pend.delete();
    send_chk(8'h1C, "t7.next");
    chk("t7.next_make", {evt_valid, evt_make}, 2'b11);

    // overflow in the middle of an E0 sequence
    send_chk(8'h12, "t8.sh");
    send_chk(8'hE0, "t8.e0");
    ovf_pulse("t8.ovf");
    chk("t8.shift_clr", shift, 1'b0);
    @(negedge clk);
    chk("t8.err_pulse", err, 1'b0);
    e_err = 0;
    send_chk(8'h75, "t8.after");
    chk("t8.plain", evt_ext, 1'b0);

    // press counter wrap
    do_reset();
    for (int i = 0; i < 260; i++) send_chk((i % 2 == 0) ? 8'h1B : 8'h1C, "wrap");
    chk("wrap.cnt", press_cnt, 8'h04);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 2) begin
        ovf_pulse("rnd.ovf");
      end else begin
        case ($urandom_range(0, 15))
          0:  rb = 8'hE0;
          1:  rb = 8'hF0;
          2:  rb = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
          3:  rb = 8'h12;
          4:  rb = 8'h59;
          5:  rb = 8'h14;
          6:  rb = 8'h11;
          7:  rb = 8'h58;
          8:  rb = 8'hAA;
          9:  rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
          10: rb = 8'($urandom);
          11: rb = 8'h1B;
          12: rb = 8'h23;
          13: rb = 8'h75;
          14: rb = 8'h6B;
          default: rb = 8'h1C;
        endcase
        send_chk(rb, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
